// File: rtl/mem_stage_ctrl.sv
// Memory stage of the WISC pipeline: takes one instruction from execute, runs loads/stores
// against a stalling data memory, and emits a single-cycle writeback record.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_halt,
  input  logic        ex_wb_en,
  input  logic [2:0]  ex_wb_reg,
  input  logic [15:0] ex_addr,
  input  logic [15:0] ex_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_stall,
  input  logic        dmem_done,
  input  logic [15:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic        wb_halt,
  output logic [2:0]  wb_reg,
  output logic [15:0] wb_data,
  output logic        mem_enable,
  output logic        mem_write,
  output logic [15:0] addr,
  output logic [15:0] write_data,
  output logic        dump,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        accept_s;
  logic        is_mem_s;
  logic        misalign_s;
  logic        to_halt_s;
  logic        we_r;
  logic        wb_en_lat_r;
  logic [2:0]  reg_lat_r;
  logic [15:0] addr_lat_r;
  logic [15:0] wdata_lat_r;
  logic        wb_valid_r;
  logic        wb_en_r;
  logic        wb_halt_r;
  logic [2:0]  wb_reg_r;
  logic [15:0] wb_data_r;
  logic        dump_r;
  logic        err_r;

  assign ex_ready   = (state_r == IDLE) && !rst;
  assign accept_s   = ex_valid && ex_ready;
  assign is_mem_s   = ex_mem_read | ex_mem_write;
  assign misalign_s = is_mem_s & ex_addr[0];
  assign to_halt_s  = ex_halt | misalign_s;

  // Next-state decode; a misaligned access is treated as a halt with the error flag.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && to_halt_s) begin
          state_nxt_s = HALTED;
        end else if (accept_s && is_mem_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (!dmem_stall) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (dmem_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HALTED:  state_nxt_s = HALTED;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Instruction latch, captured on acceptance and held for the duration of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r        <= 1'b0;
      wb_en_lat_r <= 1'b0;
      reg_lat_r   <= 3'd0;
      addr_lat_r  <= 16'd0;
      wdata_lat_r <= 16'd0;
    end else if (accept_s) begin
      we_r        <= ex_mem_write;
      wb_en_lat_r <= ex_wb_en;
      reg_lat_r   <= ex_wb_reg;
      addr_lat_r  <= ex_addr;
      wdata_lat_r <= ex_wdata;
    end else begin
      we_r        <= we_r;
      wb_en_lat_r <= wb_en_lat_r;
      reg_lat_r   <= reg_lat_r;
      addr_lat_r  <= addr_lat_r;
      wdata_lat_r <= wdata_lat_r;
    end
  end

  // Writeback record: valid/halt/dump pulse for one cycle, payload holds between records.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r <= 1'b0;
      wb_en_r    <= 1'b0;
      wb_halt_r  <= 1'b0;
      wb_reg_r   <= 3'd0;
      wb_data_r  <= 16'd0;
      dump_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      wb_valid_r <= 1'b0;
      wb_halt_r  <= 1'b0;
      dump_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && to_halt_s) begin
            wb_valid_r <= 1'b1;
            wb_en_r    <= 1'b0;
            wb_halt_r  <= 1'b1;
            wb_reg_r   <= ex_wb_reg;
            wb_data_r  <= ex_addr;
            dump_r     <= 1'b1;
            err_r      <= err_r | misalign_s;
          end else if (accept_s && !is_mem_s) begin
            wb_valid_r <= 1'b1;
            wb_en_r    <= ex_wb_en;
            wb_reg_r   <= ex_wb_reg;
            wb_data_r  <= ex_addr;
          end else begin
            wb_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (dmem_done) begin
            wb_valid_r <= 1'b1;
            wb_en_r    <= wb_en_lat_r & !we_r;
            wb_reg_r   <= reg_lat_r;
            wb_data_r  <= we_r ? addr_lat_r : dmem_rdata;
          end else begin
            wb_valid_r <= 1'b0;
          end
        end
        default: wb_valid_r <= 1'b0;
      endcase
    end
  end

  assign dmem_req   = (state_r == REQ);
  assign dmem_we    = dmem_req & we_r;
  assign dmem_addr  = addr_lat_r;
  assign dmem_wdata = wdata_lat_r;

  assign wb_valid = wb_valid_r;
  assign wb_en    = wb_en_r;
  assign wb_halt  = wb_halt_r;
  assign wb_reg   = wb_reg_r;
  assign wb_data  = wb_data_r;
  assign dump     = dump_r;
  assign err      = err_r;

  assign mem_enable = dmem_req & !dmem_we;
  assign mem_write  = dmem_req & dmem_we;
  assign addr       = dmem_addr;
  assign write_data = dmem_wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU vector table plus hand-written load/store/halt/reset sequences.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_halt;
  logic        ex_wb_en;
  logic [2:0]  ex_wb_reg;
  logic [15:0] ex_addr;
  logic [15:0] ex_wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_stall;
  logic        dmem_done;
  logic [15:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_en;
  logic        wb_halt;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        mem_enable;
  logic        mem_write;
  logic [15:0] addr;
  logic [15:0] write_data;
  logic        dump;
  logic        err;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] a;
    logic [2:0]  dst;
    logic        en;
    logic [15:0] exp_data;
    logic [2:0]  exp_reg;
    logic        exp_en;
  } alu_vec_t;

  alu_vec_t vecs [4];

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
    .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_stall(dmem_stall), .dmem_done(dmem_done), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_halt(wb_halt), .wb_reg(wb_reg), .wb_data(wb_data),
    .mem_enable(mem_enable), .mem_write(mem_write), .addr(addr), .write_data(write_data),
    .dump(dump), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_halt = 1'b0;
    ex_wb_en = 1'b0; ex_wb_reg = 3'd0; ex_addr = 16'd0; ex_wdata = 16'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alu_op(input logic [15:0] a, input logic [2:0] dst);
    idle_inputs();
    ex_valid = 1'b1; ex_wb_en = 1'b1; ex_wb_reg = dst; ex_addr = a;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    vecs[0] = '{16'h1234, 3'd3, 1'b1, 16'h1234, 3'd3, 1'b1};
    vecs[1] = '{16'hFFFF, 3'd7, 1'b1, 16'hFFFF, 3'd7, 1'b1};
    vecs[2] = '{16'h0001, 3'd0, 1'b0, 16'h0001, 3'd0, 1'b0};
    vecs[3] = '{16'hA5A5, 3'd5, 1'b1, 16'hA5A5, 3'd5, 1'b1};

    idle_inputs();
    dmem_stall = 1'b0; dmem_done = 1'b0; dmem_rdata = 16'd0;
    rst = 1'b1;
    step();
    step();
    chk1("rst_ex_ready", ex_ready, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_dmem_req", dmem_req, 1'b0);
    chk16("rst_wb_data", wb_data, 16'h0000);
    chk1("rst_err", err, 1'b0);
    rst = 1'b0;
    #1;
    chk1("ready_after_rst", ex_ready, 1'b1);

    // ALU vectors back to back: one writeback per cycle, never a memory request
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      ex_valid = 1'b1; ex_addr = vecs[i].a; ex_wb_reg = vecs[i].dst; ex_wb_en = vecs[i].en;
      step();
      chk1("alu_wb_valid", wb_valid, 1'b1);
      chk16("alu_wb_data", wb_data, vecs[i].exp_data);
      chk16("alu_wb_reg", {13'd0, wb_reg}, {13'd0, vecs[i].exp_reg});
      chk1("alu_wb_en", wb_en, vecs[i].exp_en);
      chk1("alu_no_req", dmem_req, 1'b0);
      chk1("alu_ready", ex_ready, 1'b1);
    end
    idle_inputs();
    step();
    chk1("alu_idle_valid", wb_valid, 1'b0);
    chk16("alu_hold_data", wb_data, 16'hA5A5);
    chk16("alu_hold_reg", {13'd0, wb_reg}, 16'd5);

    // Load 0x0040, no stall, done in second WAIT cycle
    idle_inputs();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_wb_reg = 3'd5; ex_addr = 16'h0040;
    step();
    idle_inputs();
    chk1("ld_req", dmem_req, 1'b1);
    chk1("ld_mem_enable", mem_enable, 1'b1);
    chk1("ld_mem_write", mem_write, 1'b0);
    chk16("ld_addr", addr, 16'h0040);
    chk1("ld_busy", ex_ready, 1'b0);
    step();
    chk1("ld_wait_req", dmem_req, 1'b0);
    chk1("ld_wait_mem_enable", mem_enable, 1'b0);
    step();
    dmem_done = 1'b1; dmem_rdata = 16'hBEEF;
    chk1("ld_wait2_valid", wb_valid, 1'b0);
    chk1("ld_wait2_busy", ex_ready, 1'b0);
    step();
    dmem_done = 1'b0; dmem_rdata = 16'h0000;
    chk1("ld_wb_valid", wb_valid, 1'b1);
    chk16("ld_wb_data", wb_data, 16'hBEEF);
    chk1("ld_wb_en", wb_en, 1'b1);
    chk16("ld_wb_reg", {13'd0, wb_reg}, 16'd5);
    chk1("ld_ready_again", ex_ready, 1'b1);
    step();
    chk1("ld_wb_pulse", wb_valid, 1'b0);

    // Store 0x0010/0x00AA with 3 stall cycles; a done during REQ must be ignored
    idle_inputs();
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_wb_en = 1'b1; ex_wb_reg = 3'd2;
    ex_addr = 16'h0010; ex_wdata = 16'h00AA;
    dmem_stall = 1'b1;
    step();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      dmem_stall = (c < 3) ? 1'b1 : 1'b0;
      dmem_done = (c == 0) ? 1'b1 : 1'b0;
      chk1("st_req", dmem_req, 1'b1);
      chk1("st_mem_write", mem_write, 1'b1);
      chk1("st_mem_enable", mem_enable, 1'b0);
      chk16("st_addr", addr, 16'h0010);
      chk16("st_wdata", write_data, 16'h00AA);
      chk1("st_no_wb", wb_valid, 1'b0);
      step();
    end
    dmem_stall = 1'b0;
    chk1("st_wait_req", dmem_req, 1'b0);
    chk1("st_wait_no_wb", wb_valid, 1'b0);
    dmem_done = 1'b1;
    step();
    dmem_done = 1'b0;
    chk1("st_wb_valid", wb_valid, 1'b1);
    chk1("st_wb_en", wb_en, 1'b0);
    chk16("st_wb_data", wb_data, 16'h0010);

    // Reset during WAIT abandons the access; late done ignored
    idle_inputs();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_wb_reg = 3'd1; ex_addr = 16'h0020;
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rstw_req", dmem_req, 1'b0);
    chk1("rstw_no_wb", wb_valid, 1'b0);
    dmem_done = 1'b1; dmem_rdata = 16'h1111;
    step();
    dmem_done = 1'b0;
    chk1("rstw_late_done", wb_valid, 1'b0);
    alu_op(16'h5555, 3'd2);
    step();
    idle_inputs();
    chk1("rstw_alu_valid", wb_valid, 1'b1);
    chk16("rstw_alu_data", wb_data, 16'h5555);

    // Halt after two ALU ops
    alu_op(16'h0101, 3'd1);
    step();
    chk16("h_alu1", wb_data, 16'h0101);
    alu_op(16'h0202, 3'd4);
    step();
    chk16("h_alu2", wb_data, 16'h0202);
    chk1("h_alu2_valid", wb_valid, 1'b1);
    idle_inputs();
    ex_valid = 1'b1; ex_halt = 1'b1; ex_wb_en = 1'b1;
    step();
    idle_inputs();
    chk1("h_dump", dump, 1'b1);
    chk1("h_wb_halt", wb_halt, 1'b1);
    chk1("h_wb_valid", wb_valid, 1'b1);
    chk1("h_wb_en", wb_en, 1'b0);
    chk1("h_ready", ex_ready, 1'b0);
    chk1("h_err", err, 1'b0);
    dmem_done = 1'b1;
    alu_op(16'h0303, 3'd3);
    step();
    dmem_done = 1'b0;
    idle_inputs();
    chk1("h_dump_pulse", dump, 1'b0);
    chk1("h_halt_pulse", wb_halt, 1'b0);
    step();
    chk1("h_done_ignored", wb_valid, 1'b0);
    chk1("h_no_req", dmem_req, 1'b0);
    chk1("h_still_busy", ex_ready, 1'b0);

    // Misaligned load
    do_reset();
    idle_inputs();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_wb_reg = 3'd6; ex_addr = 16'h0041;
    step();
    idle_inputs();
    chk1("mis_err", err, 1'b1);
    chk1("mis_dump", dump, 1'b1);
    chk1("mis_wb_halt", wb_halt, 1'b1);
    chk1("mis_wb_en", wb_en, 1'b0);
    chk1("mis_no_req", dmem_req, 1'b0);
    step();
    chk1("mis_dump_pulse", dump, 1'b0);
    chk1("mis_err_sticky", err, 1'b1);
    chk1("mis_ready", ex_ready, 1'b0);
    chk1("mis_no_req2", dmem_req, 1'b0);
    do_reset();
    #1;
    chk1("mis_err_cleared", err, 1'b0);
    chk1("mis_ready_after_rst", ex_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory stage of the WISC pipeline, between execute and writeback. Accepts one instruction per handshake from execute and issues loads and stores to a multi-cycle, stalling data memory. Holds the instruction until memory completes, then presents a single-cycle writeback record. Drives the memory-activity and halt observation signals that the trace bench samples.

## Interface
- No parameters; data and address width are fixed at 16 bits.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept this cycle.
- ex_mem_read, ex_mem_write, ex_halt  in  1 each  op class; at most one set.
- ex_wb_en  in  1  instruction writes a register.
- ex_wb_reg  in  3  destination register.
- ex_addr  in  16  memory address, or ALU result for non-memory ops.
- ex_wdata  in  16  store data.
- dmem_req, dmem_we  out  1 each  request valid; write enable.
- dmem_addr, dmem_wdata  out  16 each  request address and store data.
- dmem_stall  in  1  memory busy; the request is not taken this cycle.
- dmem_done  in  1  access complete; dmem_rdata is valid this cycle.
- dmem_rdata  in  16  load data.
- wb_valid, wb_en, wb_halt  out  1 each  writeback record valid, write enable, halt.
- wb_reg  out  3, wb_data  out  16  writeback destination and data.
- mem_enable, mem_write  out  1 each  observation signals: read issued, write issued.
- addr, write_data  out  16 each  observation copies of dmem_addr and dmem_wdata.
- dump  out  1  one-cycle pulse when a halt retires.
- err  out  1  sticky misaligned-access flag.

## Operation
- FSM states:
  - IDLE: accepting instructions.
  - REQ: dmem_req asserted.
  - WAIT: waiting for dmem_done.
  - HALTED: stopped until reset.
- ex_ready = (state==IDLE) && !rst.
- An instruction is accepted when ex_valid && ex_ready. The stage latches all ex_* fields on acceptance.
- Non-memory op, IDLE→IDLE:
  - Next cycle: wb_valid=1, wb_data=latched ex_addr, wb_en and wb_reg as latched.
- Memory op with addr[0]==0, IDLE→REQ:
  - REQ: dmem_req=1, dmem_we=latched write flag, dmem_addr and dmem_wdata from the latch.
  - REQ→WAIT on the first REQ cycle with dmem_stall==0. Otherwise stay in REQ with the request held stable.
  - WAIT: dmem_req=0. The stage ignores dmem_done during REQ.
  - WAIT→IDLE on dmem_done. Next cycle: wb_valid=1 with wb_data=dmem_rdata for a load, or the latched address for a store. wb_en is forced 0 for stores.
- Misaligned memory op (addr[0]==1), IDLE→HALTED:
  - No dmem_req is issued.
  - Next cycle: wb_valid=1, wb_en=0, wb_halt=1, dump=1. err is set and held until reset.
- Halt (ex_halt), IDLE→HALTED:
  - Next cycle: wb_valid=1, wb_en=0, wb_halt=1, dump=1 for exactly one cycle.
- HALTED: ex_ready=0, no requests. dmem_done is ignored.
- Observation signals, combinational from current outputs:
  - mem_enable = dmem_req & !dmem_we.
  - mem_write = dmem_req & dmem_we.
  - addr = dmem_addr, write_data = dmem_wdata.
- wb_valid, wb_halt and dump are registered single-cycle pulses. wb_reg, wb_data and wb_en hold their last values when wb_valid=0.

## Timing
- Reset: state=IDLE. All outputs 0 except ex_ready, which is 1 in the first cycle after rst deasserts.
- rst during REQ or WAIT abandons the access:
  - dmem_req is 0 in the cycle after the rst edge.
  - A late dmem_done is ignored.
  - No wb_valid is produced.
- Non-memory op: accepted at edge N, wb_valid in cycle N+1. Back-to-back ops give one writeback per cycle.
- Memory op: accepted at edge N; REQ from cycle N+1.
  - With s stall cycles and done arriving d cycles after entering WAIT (d≥1), wb_valid is in cycle N+1+s+1+d.
  - ex_ready=0 from N+1 until the cycle after done.
- Halt or misaligned op accepted at edge N: dump and wb_halt in cycle N+1. ex_ready stays 0 from N+1 until reset.
- dmem_done while in IDLE or HALTED is ignored with no side effects.

## Test plan
- Reset release, then ALU op ex_addr=0x1234, wb_reg=3 → next cycle wb_valid=1, wb_en=1, wb_reg=3, wb_data=0x1234; dmem_req never asserted.
- Load addr=0x0040, no stall, done 2 cycles into WAIT with rdata=0xBEEF:
  - mem_enable=1 for exactly one cycle with addr=0x0040.
  - wb_data=0xBEEF one cycle after done.
- Store addr=0x0010, wdata=0x00AA, dmem_stall held 3 cycles:
  - dmem_req, addr and wdata stable for 4 cycles; mem_write=1 throughout.
  - wb_en=0 at retire.
- Load addr=0x0041 → err=1, dump=1 for one cycle, no dmem_req; ex_ready stays 0 afterwards.
- Halt after two ALU ops → two writebacks, then dump=1 with wb_halt=1; a later dmem_done is ignored.
- rst asserted in WAIT → dmem_req=0 and no wb_valid; a done 1 cycle later is ignored; next ALU op retires normally.
